// File: rtl/pcie_us_msi_pkg.sv
// Shared types and helpers for the UltraScale+ PCIe MSI request controller.
package pcie_us_msi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        BACKOFF
    } msi_state_e;

    localparam int MSI_VEC_MAX = 32;

    // Low vector bits usable when the host granted 2^mmen vectors (capped at 32).
    function automatic logic [4:0] vec_mask(input logic [2:0] mmen);
        logic [4:0] m;
        m = '0;
        for (int b = 0; b < 5; b++) begin
            if (b < int'(mmen)) m[b] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/pcie_us_msi_rr_arb.sv
// Combinational round-robin select: first set pending bit at or after rr_ptr, wrapping.
module pcie_us_msi_rr_arb
    import pcie_us_msi_pkg::*;
#(
    parameter int N     = 32,
    parameter int PTR_W = 5
) (
    input  logic [N-1:0]     pending,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [PTR_W-1:0] grant,
    output logic             valid
);

    always_comb begin
        int idx;
        grant = '0;
        valid = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!valid && pending[idx]) begin
                valid = 1'b1;
                grant = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/pcie_us_msi_ctrl.sv
// Turns per-source irq pulses into one-hot MSI requests on the PCIe IP cfg_interrupt_msi ports.
// Optional feature: define PCIE_MSI_RETRY_EN to re-arm failed vectors after RETRY_DELAY cycles.
module pcie_us_msi_ctrl
    import pcie_us_msi_pkg::*;
#(
    parameter int IRQ_COUNT   = 32,
    parameter int RETRY_DELAY = 64,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [IRQ_COUNT-1:0]   irq,
    input  logic [3:0]             cfg_interrupt_msi_enable,
    input  logic [11:0]            cfg_interrupt_msi_mmenable,
    output logic [MSI_VEC_MAX-1:0] cfg_interrupt_msi_int,
    input  logic                   cfg_interrupt_msi_sent,
    input  logic                   cfg_interrupt_msi_fail,
    output logic                   busy,
    output logic [CNT_WIDTH-1:0]   sent_count,
    output logic [CNT_WIDTH-1:0]   drop_count
);

    localparam int PTR_W = (IRQ_COUNT > 1) ? $clog2(IRQ_COUNT) : 1;

    msi_state_e             state_q, state_d;
    logic [IRQ_COUNT-1:0]   pending_q, pending_d;
    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]       grant_q, grant_d;
    logic [PTR_W-1:0]       arb_grant;
    logic                   arb_valid;
    logic [4:0]             grant_vec;
    logic [MSI_VEC_MAX-1:0] msi_int_q, msi_int_d;
    logic [CNT_WIDTH-1:0]   sent_q, sent_d;
    logic [CNT_WIDTH-1:0]   drop_q, drop_d;
    logic                   unused_cfg;

`ifdef PCIE_MSI_RETRY_EN
    localparam int BO_W = (RETRY_DELAY > 1) ? $clog2(RETRY_DELAY) : 1;
    logic [BO_W-1:0] bo_cnt_q, bo_cnt_d;
`endif

    assign unused_cfg = ^{cfg_interrupt_msi_enable[3:1], cfg_interrupt_msi_mmenable[11:3]};

    pcie_us_msi_rr_arb #(
        .N     (IRQ_COUNT),
        .PTR_W (PTR_W)
    ) u_arb (
        .pending (pending_q),
        .rr_ptr  (rr_ptr_q),
        .grant   (arb_grant),
        .valid   (arb_valid)
    );

    // Aliased sources collapse onto the granted vector count sampled at issue time.
    assign grant_vec = 5'(arb_grant) & vec_mask(cfg_interrupt_msi_mmenable[2:0]);

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        msi_int_d = '0;
        sent_d    = sent_q;
        drop_d    = drop_q;
`ifdef PCIE_MSI_RETRY_EN
        bo_cnt_d  = bo_cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (cfg_interrupt_msi_enable[0] && arb_valid) begin
                    state_d   = ISSUE;
                    grant_d   = arb_grant;
                    msi_int_d = MSI_VEC_MAX'(1) << grant_vec;
                end
            end
            ISSUE: begin
                pending_d[grant_q] = 1'b0;
                rr_ptr_d = (grant_q == PTR_W'(IRQ_COUNT - 1)) ? '0 : grant_q + 1'b1;
                state_d  = WAIT;
            end
            WAIT: begin
                // A simultaneous sent+fail is treated as a failure.
                if (cfg_interrupt_msi_fail) begin
`ifdef PCIE_MSI_RETRY_EN
                    bo_cnt_d = '0;
                    state_d  = BACKOFF;
`else
                    if (drop_q != '1) drop_d = drop_q + 1'b1;
                    state_d = IDLE;
`endif
                end else if (cfg_interrupt_msi_sent) begin
                    if (sent_q != '1) sent_d = sent_q + 1'b1;
                    state_d = IDLE;
                end
            end
            BACKOFF: begin
`ifdef PCIE_MSI_RETRY_EN
                if (bo_cnt_q == BO_W'(RETRY_DELAY - 1)) begin
                    pending_d[grant_q] = 1'b1;
                    state_d = IDLE;
                end else begin
                    bo_cnt_d = bo_cnt_q + 1'b1;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
        // New requests win over the ISSUE clear.
        pending_d = pending_d | irq;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            msi_int_q <= '0;
            sent_q    <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            msi_int_q <= msi_int_d;
            sent_q    <= sent_d;
            drop_q    <= drop_d;
        end
    end

`ifdef PCIE_MSI_RETRY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bo_cnt_q <= '0;
        end else begin
            bo_cnt_q <= bo_cnt_d;
        end
    end
`endif

    assign cfg_interrupt_msi_int = msi_int_q;
    assign busy                  = (state_q != IDLE) | (|pending_q);
    assign sent_count            = sent_q;
    assign drop_count            = drop_q;

endmodule

// File: tb/tb_pcie_us_msi_ctrl.sv
// Bench for pcie_us_msi_ctrl: directed table, corner sequences, and random traffic vs a model.
`timescale 1ns/100ps
module tb_pcie_us_msi_ctrl;

    localparam int IRQ_COUNT   = 32;
    localparam int RETRY_DELAY = 64;
    localparam int CNT_WIDTH   = 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [31:0]          irq = '0;
    logic [3:0]           enable = 4'b0001;
    logic [11:0]          mmenable = 12'd5;
    logic [31:0]          msi_int;
    logic                 sent = 1'b0;
    logic                 fail = 1'b0;
    logic                 busy;
    logic [CNT_WIDTH-1:0] sent_count;
    logic [CNT_WIDTH-1:0] drop_count;

    int total = 0;
    int bad = 0;

    pcie_us_msi_ctrl #(
        .IRQ_COUNT   (IRQ_COUNT),
        .RETRY_DELAY (RETRY_DELAY),
        .CNT_WIDTH   (CNT_WIDTH)
    ) dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .irq                        (irq),
        .cfg_interrupt_msi_enable   (enable),
        .cfg_interrupt_msi_mmenable (mmenable),
        .cfg_interrupt_msi_int      (msi_int),
        .cfg_interrupt_msi_sent     (sent),
        .cfg_interrupt_msi_fail     (fail),
        .busy                       (busy),
        .sent_count                 (sent_count),
        .drop_count                 (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          src;
        logic [2:0]  mm;
        logic [31:0] exp;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        irq   = '0;
        sent  = 1'b0;
        fail  = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic wait_msi(output logic [31:0] v, output int n);
        n = 0;
        while (msi_int == 0 && n < 200) begin
            step();
            n++;
        end
        v = msi_int;
    endtask

    // Called at the sample where msi_int is high: acknowledge once the DUT is waiting.
    task automatic respond_sent();
        step();
        sent = 1'b1;
        step();
        sent = 1'b0;
    endtask

    function automatic int rr_pick(input logic [31:0] p, input int ptr);
        for (int k = 0; k < 32; k++) begin
            if (p[(ptr + k) % 32]) return (ptr + k) % 32;
        end
        return -1;
    endfunction

    function automatic logic [31:0] msi_exp(input int src, input logic [2:0] mm);
        int n;
        logic [31:0] one;
        n   = (mm > 3'd5) ? 5 : int'(mm);
        one = 32'd1;
        return one << (src & ((1 << n) - 1));
    endfunction

    task automatic rand_phase(input int cycles, input logic [2:0] mm);
        logic [31:0] mpend, irq_prev, irq_now;
        int ptr, g, wait_cnt, n_sent, n_drop;
        bit outstanding, en_prev, en_now, err;
        do_reset();
        mmenable    = {9'd0, mm};
        enable      = 4'b0001;
        mpend       = '0;
        irq_prev    = '0;
        ptr         = 0;
        wait_cnt    = 0;
        n_sent      = 0;
        n_drop      = 0;
        outstanding = 1'b0;
        en_prev     = 1'b1;
        for (int c = 0; c < cycles + 600; c++) begin
            sent = 1'b0;
            fail = 1'b0;
            if (msi_int != 0) begin
                total++;
                g   = rr_pick(mpend, ptr);
                err = outstanding || (g < 0) || !en_prev;
                if (!err && msi_int != msi_exp(g, mm)) err = 1'b1;
                if (err) begin
                    bad++;
                    $display("FAIL rand_msi cyc=%0d: got 0x%0h model_grant=%0d pend=0x%0h", c,
                             msi_int, g, mpend);
                end
                mpend = mpend | irq_prev;
                if (g >= 0) begin
                    mpend[g] = 1'b0;
                    ptr = (g + 1) % 32;
                end
                outstanding = 1'b1;
                wait_cnt    = $urandom_range(1, 4);
            end else begin
                mpend = mpend | irq_prev;
                if (outstanding) begin
                    wait_cnt--;
                    if (wait_cnt == 0) begin
                        outstanding = 1'b0;
`ifndef PCIE_MSI_RETRY_EN
                        if ($urandom_range(0, 7) == 0) begin
                            fail = 1'b1;
                            sent = 1'($urandom_range(0, 1));
                            n_drop++;
                        end else begin
                            sent = 1'b1;
                            n_sent++;
                        end
`else
                        sent = 1'b1;
                        n_sent++;
`endif
                    end
                end
            end
            if (c < cycles) begin
                irq_now = $urandom & $urandom & $urandom;
                if ($urandom_range(0, 1) == 0) irq_now = '0;
                en_now = ($urandom_range(0, 15) == 0) ? !en_prev : en_prev;
            end else begin
                irq_now = '0;
                en_now  = 1'b1;
            end
            irq      = irq_now;
            enable   = {3'b000, en_now};
            irq_prev = irq_now;
            en_prev  = en_now;
            step();
        end
        sent = 1'b0;
        fail = 1'b0;
        step();
        check($sformatf("rand%0d_busy", mm), {63'd0, busy}, 64'd0);
        check($sformatf("rand%0d_model_drained", mm), {32'd0, mpend}, 64'd0);
        check($sformatf("rand%0d_sent_count", mm), 64'(sent_count), 64'(n_sent));
        check($sformatf("rand%0d_drop_count", mm), 64'(drop_count), 64'(n_drop));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[8];
        logic [31:0] v;
        logic [31:0] seen;
        int          n;

        tbl[0] = '{src: 3,  mm: 3'd5, exp: 32'h0000_0008};
        tbl[1] = '{src: 6,  mm: 3'd2, exp: 32'h0000_0004};
        tbl[2] = '{src: 31, mm: 3'd5, exp: 32'h8000_0000};
        tbl[3] = '{src: 31, mm: 3'd0, exp: 32'h0000_0001};
        tbl[4] = '{src: 9,  mm: 3'd3, exp: 32'h0000_0002};
        tbl[5] = '{src: 17, mm: 3'd4, exp: 32'h0000_0002};
        tbl[6] = '{src: 22, mm: 3'd7, exp: 32'h0040_0000};
        tbl[7] = '{src: 13, mm: 3'd1, exp: 32'h0000_0002};

        do_reset();
        check("reset_msi_int", {32'd0, msi_int}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_sent_count", 64'(sent_count), 64'd0);
        check("reset_drop_count", 64'(drop_count), 64'd0);

        // Directed single-source table: latency, one-cycle pulse, vector aliasing.
        for (int r = 0; r < 8; r++) begin
            mmenable = {9'd0, tbl[r].mm};
            irq = 32'd1 << tbl[r].src;
            step();
            irq = '0;
            check($sformatf("row%0d_lat1", r), {32'd0, msi_int}, 64'd0);
            step();
            check($sformatf("row%0d_msi", r), {32'd0, msi_int}, {32'd0, tbl[r].exp});
            step();
            check($sformatf("row%0d_pulse_len", r), {32'd0, msi_int}, 64'd0);
            check($sformatf("row%0d_busy_wait", r), {63'd0, busy}, 64'd1);
            sent = 1'b1;
            step();
            sent = 1'b0;
            check($sformatf("row%0d_busy_done", r), {63'd0, busy}, 64'd0);
            check($sformatf("row%0d_sent_count", r), 64'(sent_count), 64'(r + 1));
        end

        // Two sources in the same cycle, round-robin from pointer 0.
        do_reset();
        mmenable = 12'd5;
        irq = 32'h0000_0011;
        step();
        irq = '0;
        wait_msi(v, n);
        check("rr_first", {32'd0, v}, 64'h1);
        check("rr_first_latency", 64'(n), 64'd1);
        respond_sent();
        wait_msi(v, n);
        check("rr_second", {32'd0, v}, 64'h10);
        respond_sent();
        check("rr_sent_count", 64'(sent_count), 64'd2);

        // Requests are held while MSI is disabled.
        enable = 4'b0000;
        irq = 32'h0000_0002;
        step();
        irq = '0;
        seen = '0;
        for (int i = 0; i < 10; i++) begin
            step();
            seen = seen | msi_int;
        end
        check("disabled_no_msi", {32'd0, seen}, 64'd0);
        check("disabled_busy", {63'd0, busy}, 64'd1);
        enable = 4'b0001;
        wait_msi(v, n);
        check("enabled_msi", {32'd0, v}, 64'h2);
        respond_sent();

        // Failure handling.
        do_reset();
        irq = 32'h0000_0004;
        step();
        irq = '0;
        wait_msi(v, n);
        check("fail_msi", {32'd0, v}, 64'h4);
        step();
        fail = 1'b1;
        step();
        fail = 1'b0;
`ifdef PCIE_MSI_RETRY_EN
        wait_msi(v, n);
        check("retry_msi", {32'd0, v}, 64'h4);
        check("retry_delay", 64'(n), 64'(RETRY_DELAY + 1));
        respond_sent();
        check("retry_drop_count", 64'(drop_count), 64'd0);
        check("retry_sent_count", 64'(sent_count), 64'd1);
`else
        check("drop_count", 64'(drop_count), 64'd1);
        seen = '0;
        for (int i = 0; i < 100; i++) begin
            step();
            seen = seen | msi_int;
        end
        check("drop_no_reissue", {32'd0, seen}, 64'd0);
        check("drop_busy", {63'd0, busy}, 64'd0);
        check("drop_sent_count", 64'(sent_count), 64'd0);
`endif

        // Asynchronous reset while an MSI is in flight.
        do_reset();
        irq = 32'h0000_0020;
        step();
        irq = '0;
        wait_msi(v, n);
        respond_sent();
        irq = 32'h0000_0020;
        step();
        irq = '0;
        wait_msi(v, n);
        check("rst_pre_msi", {32'd0, v}, 64'h20);
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_msi", {32'd0, msi_int}, 64'd0);
        check("rst_async_busy", {63'd0, busy}, 64'd0);
        check("rst_async_sent_count", 64'(sent_count), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        sent = 1'b1;
        step();
        sent = 1'b0;
        step();
        check("rst_late_sent_ignored", 64'(sent_count), 64'd0);
        check("rst_late_busy", {63'd0, busy}, 64'd0);
        irq = 32'h0000_0020;
        step();
        irq = '0;
        wait_msi(v, n);
        check("rst_after_msi", {32'd0, v}, 64'h20);
        respond_sent();
        check("rst_after_sent_count", 64'(sent_count), 64'd1);

        rand_phase(3000, 3'd5);
        rand_phase(3000, 3'd2);
        rand_phase(2000, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
